// File: rtl/seq_generator.sv
// seq_generator: serial pattern transmitter.
// Accepts a PAT_W-bit pattern and a repeat count through a valid/ready
// handshake, then shifts the pattern out MSB-first, one bit per clock, with
// repeats sent back-to-back. Outputs are decoded from registered state only.
// Optional feature: define SEQ_GEN_PARITY_EN to append one even-parity bit
// after every pattern repeat (PARITY state, is_parity output).
module seq_generator #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    output logic             data_out,
    output logic             bit_valid,
    output logic             is_parity,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    BCW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(PAT_W - 1);
    localparam logic [BCW-1:0] BC_ONE   = BCW'(1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [CNT_W-1:0] rep_q,   rep_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             rep_more;

    assign rep_more = (rep_q > REP_ONE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            pat_q    <= '0;
            rep_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            pat_q    <= pat_d;
            rep_q    <= rep_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pat_d    = pat_q;
        rep_d    = rep_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d  = SHIFT;
                    shreg_d  = pat_in;
                    pat_d    = pat_in;
                    rep_d    = (rep_in == '0) ? REP_ONE : rep_in;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d  = IDLE;
                    rep_d    = '0;
                    bitcnt_d = '0;
                end else begin
                    shreg_d  = {shreg_q[PAT_W-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + BC_ONE;
                    if (bitcnt_q == LAST_BIT) begin
                        bitcnt_d = '0;
`ifdef SEQ_GEN_PARITY_EN
                        state_d = PARITY;
`else
                        if (rep_more) begin
                            rep_d   = rep_q - REP_ONE;
                            shreg_d = pat_q;
                        end else begin
                            state_d = DONE;
                        end
`endif
                    end
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                if (abort) begin
                    state_d  = IDLE;
                    rep_d    = '0;
                    bitcnt_d = '0;
                end else if (rep_more) begin
                    state_d = SHIFT;
                    rep_d   = rep_q - REP_ONE;
                    shreg_d = pat_q;
                end else begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        start_ready = 1'b0;
        data_out    = 1'b0;
        bit_valid   = 1'b0;
        is_parity   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                data_out  = shreg_q[PAT_W-1];
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                is_parity = 1'b1;
                data_out  = ^pat_q;
            end
`endif
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

endmodule
